uimac_tx_arbiter: RTL and testbench

- Sequences and shares the single MAC TX byte stream between three frame sources: ch0 = MAC control (PAUSE) frames, ch1 = ARP, ch2 = IP/UDP.
- Grants one source per frame and holds the grant until that frame's last beat.
- Enforces an inter-frame gap after every frame.
- Obeys the pause flag from the TX pause controller by blocking data sources (ch1, ch2) between frames, never mid-frame.

---
 rtl/uimac_tx_arbiter.sv | 123 ++++++++++++
 tb/tb_uimac_tx_arbiter.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/uimac_tx_arbiter.sv
// uimac_tx_arbiter: shares the MAC TX byte stream between PAUSE, ARP and IP/UDP sources with IFG and stall abort
module uimac_tx_arbiter #(
  parameter int IFG_CYCLES    = 12,
  parameter int STALL_TIMEOUT = 4096
) (
  input  logic       I_clk,
  input  logic       I_reset,
  input  logic       I_pause_flag,
  input  logic       I_ch0_req,
  input  logic [7:0] I_ch0_data,
  input  logic       I_ch0_valid,
  input  logic       I_ch0_last,
  input  logic       I_ch1_req,
  input  logic [7:0] I_ch1_data,
  input  logic       I_ch1_valid,
  input  logic       I_ch1_last,
  input  logic       I_ch2_req,
  input  logic [7:0] I_ch2_data,
  input  logic       I_ch2_valid,
  input  logic       I_ch2_last,
  output logic       O_ch0_grant,
  output logic       O_ch1_grant,
  output logic       O_ch2_grant,
  output logic       O_ch0_ready,
  output logic       O_ch1_ready,
  output logic       O_ch2_ready,
  output logic [7:0] O_mac_data,
  output logic       O_mac_valid,
  output logic       O_mac_last,
  input  logic       I_mac_ready,
  output logic [1:0] O_cur_ch,
  output logic       O_busy,
  output logic       O_abort
);
  localparam int IW = $clog2(IFG_CYCLES) + 1;
  localparam int SW = $clog2(STALL_TIMEOUT) + 1;
  typedef enum logic [1:0] {IDLE, XFER, IFG} state_t;
  state_t         state_q, state_d;
  logic [2:0]     grant_q, grant_d;
  logic [1:0]     cur_ch_q, cur_ch_d;
  logic           rr_q, rr_d;
  logic [IW-1:0]  ifg_q, ifg_d;
  logic [SW-1:0]  stall_q, stall_d;
  logic           abort_q, abort_d;
  logic [2:0]     valid, last;
  logic           elig1, elig2, pick2, accept, timeout;
  assign valid = {I_ch2_valid, I_ch1_valid, I_ch0_valid};
  assign last  = {I_ch2_last, I_ch1_last, I_ch0_last};
  assign O_mac_data  = grant_q[0] ? I_ch0_data : grant_q[1] ? I_ch1_data : grant_q[2] ? I_ch2_data : 8'h00;
  assign O_mac_valid = |(grant_q & valid);
  assign O_mac_last  = |(grant_q & last);
  assign {O_ch2_grant, O_ch1_grant, O_ch0_grant} = grant_q;
  assign {O_ch2_ready, O_ch1_ready, O_ch0_ready} = grant_q & {3{I_mac_ready}};
  assign O_cur_ch = cur_ch_q;
  assign O_busy   = state_q != IDLE;
  assign O_abort  = abort_q;
  assign elig1   = I_ch1_req & ~I_pause_flag;
  assign elig2   = I_ch2_req & ~I_pause_flag;
  // rr_q=0 prefers ch1; the non-preferred data channel wins only if the preferred one is not eligible
  assign pick2   = rr_q ? elig2 : ~elig1;
  assign accept  = O_mac_valid & I_mac_ready;
  assign timeout = ~accept & (stall_q == SW'(STALL_TIMEOUT - 1));
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    cur_ch_d = cur_ch_q;
    rr_d     = rr_q;
    ifg_d    = ifg_q;
    stall_d  = stall_q;
    abort_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (I_ch0_req) begin
          grant_d  = 3'b001;
          cur_ch_d = 2'd0;
          stall_d  = '0;
          state_d  = XFER;
        end else if (elig1 | elig2) begin
          grant_d  = pick2 ? 3'b100 : 3'b010;
          cur_ch_d = pick2 ? 2'd2 : 2'd1;
          rr_d     = ~pick2;
          stall_d  = '0;
          state_d  = XFER;
        end
      end
      XFER: begin
        stall_d = accept ? '0 : stall_q + SW'(1);
        if ((accept & O_mac_last) | timeout) begin
          grant_d  = 3'b000;
          cur_ch_d = 2'd3;
          ifg_d    = IW'(IFG_CYCLES - 1);
          stall_d  = '0;
          abort_d  = timeout;
          state_d  = IFG;
        end
      end
      IFG: begin
        state_d = (ifg_q == '0) ? IDLE : IFG;
        ifg_d   = (ifg_q == '0) ? ifg_q : ifg_q - IW'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge I_clk or posedge I_reset) begin
    if (I_reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      cur_ch_q <= 2'd3;
      rr_q     <= 1'b0;
      ifg_q    <= '0;
      stall_q  <= '0;
      abort_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      cur_ch_q <= cur_ch_d;
      rr_q     <= rr_d;
      ifg_q    <= ifg_d;
      stall_q  <= stall_d;
      abort_q  <= abort_d;
    end
  end
endmodule

// File: tb/tb_uimac_tx_arbiter.sv
// tb_uimac_tx_arbiter: random and directed frames checked each cycle against a frame-level arbitration model
module tb_uimac_tx_arbiter;
  localparam int IFG = 12;
  localparam int TO  = 4096;
  logic clk = 0, rst = 1, pause = 0, mac_ready = 0;
  logic [2:0] req = '0, valid = '0, last = '0;
  logic [2:0][7:0] data = '0;
  logic [2:0] grant, ready;
  logic [7:0] mac_data;
  logic mac_valid, mac_last, busy, abort_o;
  logic [1:0] cur_ch;
  always #5 clk = ~clk;
  uimac_tx_arbiter #(.IFG_CYCLES(IFG), .STALL_TIMEOUT(TO)) dut (
    .I_clk(clk), .I_reset(rst), .I_pause_flag(pause),
    .I_ch0_req(req[0]), .I_ch0_data(data[0]), .I_ch0_valid(valid[0]), .I_ch0_last(last[0]),
    .I_ch1_req(req[1]), .I_ch1_data(data[1]), .I_ch1_valid(valid[1]), .I_ch1_last(last[1]),
    .I_ch2_req(req[2]), .I_ch2_data(data[2]), .I_ch2_valid(valid[2]), .I_ch2_last(last[2]),
    .O_ch0_grant(grant[0]), .O_ch1_grant(grant[1]), .O_ch2_grant(grant[2]),
    .O_ch0_ready(ready[0]), .O_ch1_ready(ready[1]), .O_ch2_ready(ready[2]),
    .O_mac_data(mac_data), .O_mac_valid(mac_valid), .O_mac_last(mac_last), .I_mac_ready(mac_ready),
    .O_cur_ch(cur_ch), .O_busy(busy), .O_abort(abort_o));
  int total = 0, bad = 0, cyc = 0;
  int act[3], len[3], idx[3], base[3], hold_at[3], hold[3], pend[3], plen[3], vprob[3];
  int ready_mode = 0;
  bit rtog = 1;
  int m_owner = -1, m_gap = 0, m_rr = 1, m_run = 0;
  bit m_abort = 0;
  int glog[$], gcyc[$];
  int beats = 0, aborts = 0, last_beat_cyc = 0, busy_fall = 0, prev_cur = 3;
  bit prev_busy = 0;
  task automatic chk(string nm, int a, int e);
    total++;
    if (a != e) begin
      bad++;
      $display("FAIL %s @cyc %0d: got %0d expected %0d", nm, cyc, a, e);
    end
  endtask
  function automatic void start_frame(int n, int l);
    act[n] = 1; len[n] = l; idx[n] = 0; base[n] = $urandom_range(255);
  endfunction
  task automatic drive();
    for (int n = 0; n < 3; n++) begin
      req[n]   = act[n] != 0;
      valid[n] = act[n] != 0 && !(hold[n] > 0 && idx[n] == hold_at[n]) && ($urandom_range(99) < vprob[n]);
      data[n]  = 8'(base[n] + idx[n]);
      last[n]  = act[n] != 0 && idx[n] == len[n] - 1;
    end
    if (ready_mode == 0) mac_ready = 1;
    else if (ready_mode == 1) begin mac_ready = rtog; rtog = ~rtog; end
    else mac_ready = $urandom_range(99) < 75;
  endtask
  task automatic check_update();
    int own, eg, win;
    bit e1, e2;
    own = m_owner;
    eg = own >= 0 ? (1 << own) : 0;
    chk("grant", int'(grant), eg);
    chk("ready", int'(ready), mac_ready ? eg : 0);
    chk("cur_ch", int'(cur_ch), own >= 0 ? own : 3);
    chk("busy", int'(busy), (own >= 0 || m_gap > 0) ? 1 : 0);
    chk("abort", int'(abort_o), int'(m_abort));
    chk("mac_valid", int'(mac_valid), own >= 0 ? int'(valid[own]) : 0);
    chk("mac_last", int'(mac_last), own >= 0 ? int'(last[own]) : 0);
    if (own >= 0) chk("mac_data", int'(mac_data), int'(data[own]));
    if (cur_ch != 3 && prev_cur == 3) begin glog.push_back(int'(cur_ch)); gcyc.push_back(cyc); end
    if (mac_valid && mac_ready) begin beats++; if (mac_last) last_beat_cyc = cyc; end
    if (abort_o) aborts++;
    if (!busy && prev_busy) busy_fall = cyc;
    prev_cur = int'(cur_ch);
    prev_busy = busy;
    for (int n = 0; n < 3; n++)
      if (hold[n] > 0 && act[n] != 0 && idx[n] == hold_at[n]) hold[n]--;
    m_abort = 0;
    if (own >= 0) begin
      if (valid[own] && mac_ready) begin
        m_run = 0;
        idx[own]++;
        if (last[own]) begin act[own] = 0; m_owner = -1; m_gap = IFG; end
      end else begin
        m_run++;
        if (m_run == TO) begin
          m_abort = 1; m_run = 0; act[own] = 0; hold[own] = 0; m_owner = -1; m_gap = IFG;
        end
      end
    end else if (m_gap > 0) m_gap--;
    else begin
      e1 = req[1] && !pause;
      e2 = req[2] && !pause;
      win = -1;
      if (req[0]) win = 0;
      else if (m_rr == 1 ? e1 : e2) win = m_rr;
      else if (m_rr == 1 ? e2 : e1) win = 3 - m_rr;
      if (win > 0) m_rr = 3 - win;
      if (win >= 0) begin m_owner = win; m_run = 0; end
    end
    for (int n = 0; n < 3; n++)
      if (act[n] == 0 && pend[n] > 0) begin start_frame(n, plen[n]); pend[n]--; end
  endtask
  task automatic tick();
    drive();
    #4;
    check_update();
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic drain(int max);
    int k = 0;
    while ((act[0] + act[1] + act[2] + pend[0] + pend[1] + pend[2]) != 0 || m_owner >= 0 || m_gap > 0) begin
      if (k == max) begin
        total++; bad++;
        $display("FAIL drain_timeout: still busy after %0d cycles, required idle", max);
        break;
      end
      k++;
      tick();
    end
    repeat (2) tick();
  endtask
  initial begin
    int rc, pd;
    for (int n = 0; n < 3; n++) begin
      act[n] = 0; pend[n] = 0; hold[n] = 0; hold_at[n] = 0; plen[n] = 1; vprob[n] = 100; len[n] = 1; idx[n] = 0; base[n] = 0;
    end
    @(posedge clk); #1; #4;
    chk("rst_grant", int'(grant), 0);
    chk("rst_cur", int'(cur_ch), 3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_abort", int'(abort_o), 0);
    chk("rst_valid", int'(mac_valid), 0);
    @(posedge clk); #1;
    rst = 0;
    // single ch2 frame: grant latency, byte count and gap length
    glog.delete(); gcyc.delete(); beats = 0;
    start_frame(2, 64); rc = cyc;
    drain(300);
    chk("A_grant_ch", glog.size() > 0 ? glog[0] : -1, 2);
    chk("A_grant_lat", gcyc.size() > 0 ? gcyc[0] - rc : -1, 1);
    chk("A_beats", beats, 64);
    chk("A_busy_fall", busy_fall - last_beat_cyc, IFG + 1);
    // ch1/ch2 round-robin over three frames each
    glog.delete(); gcyc.delete();
    pend[1] = 2; plen[1] = 5; pend[2] = 2; plen[2] = 5;
    start_frame(1, 5); start_frame(2, 5);
    drain(500);
    chk("B_count", glog.size(), 6);
    for (int i = 0; i < 6; i++) chk("B_order", i < glog.size() ? glog[i] : -1, (i % 2) ? 2 : 1);
    // pause blocks ch1 but not ch0
    glog.delete(); gcyc.delete();
    pause = 1;
    start_frame(0, 8); start_frame(1, 10);
    repeat (60) tick();
    chk("C_only_ch0", glog.size(), 1);
    chk("C_first", glog.size() > 0 ? glog[0] : -1, 0);
    pause = 0; pd = cyc;
    drain(200);
    chk("C_ch1_next", glog.size() > 1 ? glog[1] : -1, 1);
    chk("C_ch1_lat", gcyc.size() > 1 ? gcyc[1] - pd : -1, 1);
    // pause rising mid-frame lets the frame finish
    glog.delete(); gcyc.delete(); beats = 0;
    start_frame(2, 60);
    for (int k = 0; k < 200 && idx[2] < 10; k++) tick();
    pause = 1;
    for (int k = 0; k < 200 && act[2] != 0; k++) tick();
    start_frame(2, 8);
    repeat (50) tick();
    chk("D_beats", beats, 60);
    chk("D_grants", glog.size(), 1);
    pause = 0;
    drain(200);
    chk("D_regrant", glog.size(), 2);
    // toggling MAC ready
    glog.delete(); beats = 0; ready_mode = 1;
    start_frame(1, 20);
    drain(200);
    chk("E_beats", beats, 20);
    ready_mode = 0;
    // ch1 stalls mid-frame until the stall abort fires
    glog.delete(); gcyc.delete(); beats = 0; aborts = 0;
    start_frame(1, 20); hold_at[1] = 5; hold[1] = 5000;
    for (int k = 0; k < 50 && glog.size() == 0; k++) tick();
    repeat (3) tick();
    start_frame(2, 6);
    drain(6000);
    chk("F_aborts", aborts, 1);
    chk("F_first", glog.size() > 0 ? glog[0] : -1, 1);
    chk("F_second", glog.size() > 1 ? glog[1] : -1, 2);
    chk("F_beats", beats, 11);
    // reset in the middle of a ch1 frame
    start_frame(1, 30);
    repeat (6) tick();
    rst = 1;
    #4;
    chk("R_grant", int'(grant), 0);
    chk("R_cur", int'(cur_ch), 3);
    chk("R_busy", int'(busy), 0);
    chk("R_abort", int'(abort_o), 0);
    chk("R_valid", int'(mac_valid), 0);
    chk("R_ready", int'(ready), 0);
    @(posedge clk); #1;
    rst = 0; cyc++;
    for (int n = 0; n < 3; n++) begin act[n] = 0; pend[n] = 0; hold[n] = 0; end
    m_owner = -1; m_gap = 0; m_rr = 1; m_run = 0; m_abort = 0; prev_cur = 3; prev_busy = 0;
    repeat (3) tick();
    glog.delete();
    start_frame(1, 5); start_frame(2, 5);
    drain(200);
    chk("R_rr_ch1", glog.size() > 0 ? glog[0] : -1, 1);
    // random traffic
    ready_mode = 2;
    for (int n = 0; n < 3; n++) vprob[n] = 85;
    for (int k = 0; k < 3000; k++) begin
      for (int n = 0; n < 3; n++)
        if (act[n] == 0 && pend[n] == 0 && $urandom_range(19) == 0) start_frame(n, $urandom_range(16, 1));
      if ($urandom_range(29) == 0) pause = ~pause;
      tick();
    end
    pause = 0;
    drain(3000);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
